// File: rtl/irrigation_display_pkg.sv
// Shared display definitions for the irrigation status matrix: modes, 5x7 image type
// and the per-mode animation images (two phases each).
package irrigation_display_pkg;

    localparam int unsigned ImgCols = 5;
    localparam int unsigned ImgRows = 7;
    localparam int unsigned ImgColW = 3;

    typedef enum logic [1:0] {
        Off       = 2'b00,
        Dripper   = 2'b01,
        Sprinkler = 2'b10,
        Alarm     = 2'b11
    } mode_e;

    // Indexed [column][row bit]; bit 6 is the top row, lit = 1.
    typedef logic [ImgCols-1:0][ImgRows-1:0] image_t;

    localparam image_t IMG_OFF_P0       = {7'b0000000, 7'b0000000, 7'b1111101,
                                           7'b0000000, 7'b0000000};
    localparam image_t IMG_OFF_P1       = IMG_OFF_P0;
    localparam image_t IMG_DRIPPER_P0   = {7'b0000000, 7'b0000000, 7'b1100000,
                                           7'b0000000, 7'b0000000};
    localparam image_t IMG_DRIPPER_P1   = {7'b0000000, 7'b0000011, 7'b0000111,
                                           7'b0000011, 7'b0000000};
    localparam image_t IMG_SPRINKLER_P0 = {7'b1000001, 7'b0100010, 7'b0011111,
                                           7'b0100010, 7'b1000001};
    localparam image_t IMG_SPRINKLER_P1 = {7'b0010100, 7'b1001000, 7'b0011111,
                                           7'b1001000, 7'b0010100};
    localparam image_t IMG_ALARM_P0     = {ImgCols{7'b1111111}};
    localparam image_t IMG_ALARM_P1     = {ImgCols{7'b0000000}};

    function automatic image_t get_image(mode_e mode, logic phase);
        image_t img;
        img = IMG_OFF_P0;
        unique case (mode)
            Off:       img = phase ? IMG_OFF_P1 : IMG_OFF_P0;
            Dripper:   img = phase ? IMG_DRIPPER_P1 : IMG_DRIPPER_P0;
            Sprinkler: img = phase ? IMG_SPRINKLER_P1 : IMG_SPRINKLER_P0;
            Alarm:     img = phase ? IMG_ALARM_P1 : IMG_ALARM_P0;
            default:   img = IMG_OFF_P0;
        endcase
        return img;
    endfunction

endpackage

// File: rtl/matrix_scan_timer.sv
// Prescaler, column and frame counters for the matrix scan. All outputs describe the edge
// about to happen: col_idx_o is the column active after it, col_advance_o marks a new column.
module matrix_scan_timer #(
    parameter int unsigned NUM_COLS     = 5,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 50,
    localparam int unsigned ColW        = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    output logic [ColW-1:0] col_idx_o,
    output logic            col_advance_o,
    output logic            frame_wrap_o
);

    localparam int unsigned PreW   = $clog2(SCAN_DIV);
    localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PreW-1:0]   PreMax   = PreW'(SCAN_DIV - 1);
    localparam logic [ColW-1:0]   ColMax   = ColW'(NUM_COLS - 1);
    localparam logic [FrameW-1:0] FrameMax = FrameW'(BLINK_FRAMES - 1);

    logic              started_q;
    logic [PreW-1:0]   presc_q, presc_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [FrameW-1:0] frame_q, frame_d;
    logic              advance;
    logic              frame_wrap;

    always_comb begin
        presc_d    = '0;
        col_d      = '0;
        frame_d    = '0;
        advance    = 1'b0;
        frame_wrap = 1'b0;
        if (enable_i) begin
            if (!started_q) begin
                // First enabled edge: column 0 starts a fresh frame, nothing completed yet.
                advance = 1'b1;
            end else begin
                col_d   = col_q;
                frame_d = frame_q;
                if (presc_q == PreMax) begin
                    advance = 1'b1;
                    if (col_q == ColMax) begin
                        col_d = '0;
                        if (frame_q == FrameMax) begin
                            frame_wrap = 1'b1;
                            frame_d    = '0;
                        end else begin
                            frame_d = frame_q + FrameW'(1);
                        end
                    end else begin
                        col_d = col_q + ColW'(1);
                    end
                end else begin
                    presc_d = presc_q + PreW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            started_q <= 1'b0;
            presc_q   <= '0;
            col_q     <= '0;
            frame_q   <= '0;
        end else begin
            started_q <= enable_i;
            presc_q   <= presc_d;
            col_q     <= col_d;
            frame_q   <= frame_d;
        end
    end

    assign col_idx_o     = col_d;
    assign col_advance_o = advance;
    assign frame_wrap_o  = frame_wrap;

endmodule

// File: rtl/irrigation_matrix_scanner.sv
// Column-multiplexed 5x7 LED matrix driver showing an animated irrigation status image.
// Mode is latched per frame; the animation phase flips every BLINK_FRAMES frames.
module irrigation_matrix_scanner
    import irrigation_display_pkg::*;
#(
    parameter int unsigned NUM_COLS     = 5,
    parameter int unsigned NUM_ROWS     = 7,
    parameter int unsigned SCAN_DIV     = 1000,
    parameter int unsigned BLINK_FRAMES = 50,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_COLS-1:0] col_sel,
    output logic [NUM_ROWS-1:0] row_data,
    output logic                frame_start
);

    localparam int unsigned ColW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam logic [NUM_COLS-1:0] ColIdle = {NUM_COLS{ACTIVE_LOW != 0}};
    localparam logic [NUM_ROWS-1:0] RowIdle = {NUM_ROWS{ACTIVE_LOW != 0}};

    logic [ColW-1:0]     col_idx;
    logic                col_advance;
    logic                frame_wrap;
    logic                frame_begin;

    mode_e               mode_q, mode_d;
    logic                phase_q, phase_d;
    logic [NUM_COLS-1:0] col_sel_q, col_sel_d;
    logic [NUM_ROWS-1:0] row_data_q, row_data_d;
    logic                frame_start_q, frame_start_d;

    image_t              img;
    logic [ImgRows-1:0]  img_col;
    logic [NUM_COLS-1:0] col_lit;
    logic [NUM_ROWS-1:0] row_lit;

    matrix_scan_timer #(
        .NUM_COLS    (NUM_COLS),
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_timer (
        .clk_i        (clock),
        .rst_i        (reset),
        .enable_i     (enable),
        .col_idx_o    (col_idx),
        .col_advance_o(col_advance),
        .frame_wrap_o (frame_wrap)
    );

    // Mode and phase are resolved for the upcoming edge so a new frame shows them at once.
    always_comb begin
        frame_begin   = col_advance && (col_idx == '0);
        mode_d        = frame_begin ? mode_e'(mode) : mode_q;
        phase_d       = frame_wrap ? ~phase_q : phase_q;
        img           = get_image(mode_d, phase_d);
        img_col       = img[ImgColW'(col_idx)];
        col_lit       = '0;
        row_lit       = '0;
        if (enable) begin
            col_lit[col_idx] = 1'b1;
            row_lit          = img_col[ImgRows-1 -: NUM_ROWS];
        end
        col_sel_d     = (ACTIVE_LOW != 0) ? ~col_lit : col_lit;
        row_data_d    = (ACTIVE_LOW != 0) ? ~row_lit : row_lit;
        frame_start_d = frame_begin;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q        <= Off;
            phase_q       <= 1'b0;
            col_sel_q     <= ColIdle;
            row_data_q    <= RowIdle;
            frame_start_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            phase_q       <= phase_d;
            col_sel_q     <= col_sel_d;
            row_data_q    <= row_data_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign col_sel     = col_sel_q;
    assign row_data    = row_data_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_irrigation_matrix_scanner.sv
// Directed bench for irrigation_matrix_scanner: an active-low 5-column instance and an
// active-high 3-column instance driven from the same inputs.
module tb_irrigation_matrix_scanner;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] mode;
    logic [4:0] col_sel;
    logic [6:0] row_data;
    logic       frame_start;
    logic [2:0] col_sel_p;
    logic [6:0] row_data_p;
    logic       frame_start_p;

    int n_cmp = 0;
    int n_err = 0;

    irrigation_matrix_scanner #(
        .NUM_COLS(5), .NUM_ROWS(7), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1)
    ) dut (
        .clock(clk), .reset(reset), .enable(enable), .mode(mode),
        .col_sel(col_sel), .row_data(row_data), .frame_start(frame_start)
    );

    irrigation_matrix_scanner #(
        .NUM_COLS(3), .NUM_ROWS(7), .SCAN_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(0)
    ) dut_pol (
        .clock(clk), .reset(reset), .enable(enable), .mode(mode),
        .col_sel(col_sel_p), .row_data(row_data_p), .frame_start(frame_start_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        mode   = 2'b00;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (col_sel !== 5'b11111) begin
            n_err++; $display("FAIL reset_col_sel got %b want %b", col_sel, 5'b11111);
        end
        n_cmp++;
        if (row_data !== 7'b1111111) begin
            n_err++; $display("FAIL reset_row_data got %b want %b", row_data, 7'b1111111);
        end
        n_cmp++;
        if (frame_start !== 1'b0) begin
            n_err++; $display("FAIL reset_frame_start got %b want 0", frame_start);
        end
        n_cmp++;
        if (col_sel_p !== 3'b000) begin
            n_err++; $display("FAIL reset_pol_col_sel got %b want 000", col_sel_p);
        end
        reset = 1'b0;
    endtask

    task automatic test_scan_order();
        logic [4:0] sel_tab [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
        logic [2:0] pol_tab [3] = '{3'b001, 3'b010, 3'b100};
        int col;
        int pcol;
        logic [6:0] exp_row;
        logic [6:0] exp_row_p;
        do_reset();
        mode   = 2'b00;
        enable = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            col       = (cyc / 4) % 5;
            pcol      = (cyc / 4) % 3;
            exp_row   = (col == 2) ? 7'b0000010 : 7'b1111111;
            exp_row_p = (pcol == 2) ? 7'b1111101 : 7'b0000000;
            n_cmp++;
            if (col_sel !== sel_tab[col]) begin
                n_err++; $display("FAIL scan_col_sel cyc %0d got %b want %b", cyc, col_sel,
                                  sel_tab[col]);
            end
            n_cmp++;
            if (row_data !== exp_row) begin
                n_err++; $display("FAIL scan_row_data cyc %0d got %b want %b", cyc, row_data,
                                  exp_row);
            end
            n_cmp++;
            if (frame_start !== (cyc % 20 == 0)) begin
                n_err++; $display("FAIL scan_frame_start cyc %0d got %b want %b", cyc,
                                  frame_start, (cyc % 20 == 0));
            end
            n_cmp++;
            if (col_sel_p !== pol_tab[pcol]) begin
                n_err++; $display("FAIL pol_col_sel cyc %0d got %b want %b", cyc, col_sel_p,
                                  pol_tab[pcol]);
            end
            n_cmp++;
            if (row_data_p !== exp_row_p) begin
                n_err++; $display("FAIL pol_row_data cyc %0d got %b want %b", cyc, row_data_p,
                                  exp_row_p);
            end
            n_cmp++;
            if (frame_start_p !== (cyc % 12 == 0)) begin
                n_err++; $display("FAIL pol_frame_start cyc %0d got %b want %b", cyc,
                                  frame_start_p, (cyc % 12 == 0));
            end
        end
    endtask

    task automatic test_mid_frame_mode();
        logic [6:0] exp_row;
        do_reset();
        mode   = 2'b00;
        enable = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (cyc >= 20)     exp_row = 7'b0000000;
            else if (cyc >= 12) exp_row = 7'b1111111;
            else if (cyc >= 8)  exp_row = 7'b0000010;
            else                exp_row = 7'b1111111;
            n_cmp++;
            if (row_data !== exp_row) begin
                n_err++; $display("FAIL midframe_row_data cyc %0d got %b want %b", cyc,
                                  row_data, exp_row);
            end
            if (cyc == 9) mode = 2'b11;
        end
    endtask

    task automatic test_blink();
        logic [6:0] exp_row;
        do_reset();
        mode   = 2'b11;
        enable = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick();
            exp_row = (((cyc / 40) % 2) == 0) ? 7'b0000000 : 7'b1111111;
            n_cmp++;
            if (row_data !== exp_row) begin
                n_err++; $display("FAIL blink_row_data cyc %0d got %b want %b", cyc, row_data,
                                  exp_row);
            end
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        mode   = 2'b00;
        enable = 1'b1;
        repeat (14) tick();
        n_cmp++;
        if (col_sel !== 5'b10111) begin
            n_err++; $display("FAIL drop_pre_col_sel got %b want 10111", col_sel);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if (col_sel !== 5'b11111 || row_data !== 7'b1111111 || frame_start !== 1'b0) begin
            n_err++; $display("FAIL drop_blank got %b/%b/%b want 11111/1111111/0", col_sel,
                              row_data, frame_start);
        end
        repeat (2) tick();
        n_cmp++;
        if (col_sel !== 5'b11111 || frame_start !== 1'b0) begin
            n_err++; $display("FAIL drop_hold got %b/%b want 11111/0", col_sel, frame_start);
        end
        enable = 1'b1;
        tick();
        n_cmp++;
        if (col_sel !== 5'b11110 || frame_start !== 1'b1) begin
            n_err++; $display("FAIL reenable_first got %b/%b want 11110/1", col_sel,
                              frame_start);
        end
        tick();
        n_cmp++;
        if (col_sel !== 5'b11110 || frame_start !== 1'b0) begin
            n_err++; $display("FAIL reenable_second got %b/%b want 11110/0", col_sel,
                              frame_start);
        end
        repeat (2) tick();
        n_cmp++;
        if (col_sel !== 5'b11110) begin
            n_err++; $display("FAIL reenable_hold got %b want 11110", col_sel);
        end
        tick();
        n_cmp++;
        if (col_sel !== 5'b11101) begin
            n_err++; $display("FAIL reenable_next_col got %b want 11101", col_sel);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        mode   = 2'b00;
        enable = 1'b1;
        repeat (10) tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (col_sel !== 5'b11111 || row_data !== 7'b1111111 || frame_start !== 1'b0) begin
            n_err++; $display("FAIL midreset_blank got %b/%b/%b want 11111/1111111/0",
                              col_sel, row_data, frame_start);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (col_sel !== 5'b11110 || frame_start !== 1'b1) begin
            n_err++; $display("FAIL midreset_restart got %b/%b want 11110/1", col_sel,
                              frame_start);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        mode   = 2'b00;
        test_reset();
        test_scan_order();
        test_mid_frame_mode();
        test_blink();
        test_enable_drop();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
